// File: rtl/upd_llr_pkg.sv
// Shared definitions for the slow-PHY to LLR unpacker: lane geometry,
// FSM state encoding and a lane-extract helper.
`timescale 1ns/1ps
package upd_llr_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 8;
  localparam int WORD_W = DATA_W * LANES;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_OUT0  = 3'd3,
    ST_OUT1  = 3'd4
  } state_e;

  // Lane k of a FIFO word lives in bits [16k+15:16k].
  function automatic logic [DATA_W-1:0] lane_get(input logic [WORD_W-1:0] word,
                                                  input logic [2:0]        idx);
    lane_get = word[int'(idx) * DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/upd_llr_noise_sel.sv
// Noise word holding register plus the lane/RE counters that decide which
// noise lane accompanies each RE pair and when a fresh noise word is needed.
`timescale 1ns/1ps
module upd_llr_noise_sel
  import upd_llr_pkg::*;
(
  input  logic              i_core_clk,
  input  logic              i_rx_rstn,
  input  logic              i_fsm_rstn,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_noise_word,
  input  logic              i_advance,
  input  logic [15:0]       i_rate_eff,
  output logic [DATA_W-1:0] o_noise,
  output logic              o_need_noise
);

  logic [WORD_W-1:0] r_noise_word;
  logic [2:0]        r_nidx;
  logic [15:0]       r_nre;
  logic              r_need_noise;
  logic [16:0]       w_nre_next;

  // Extra bit so a rate near 16'hFFFF cannot wrap the compare.
  assign w_nre_next   = {1'b0, r_nre} + 17'd2;
  assign o_noise      = lane_get(r_noise_word, r_nidx);
  assign o_need_noise = r_need_noise;

  // Holding register for the most recently popped noise word.
  always_ff @(posedge i_core_clk) begin
    if (!i_rx_rstn) begin
      r_noise_word <= '0;
    end else if (i_load) begin
      r_noise_word <= i_noise_word;
    end else begin
      r_noise_word <= r_noise_word;
    end
  end

  // Lane index / RE-within-lane counters; a new user always starts with a fresh word.
  always_ff @(posedge i_core_clk) begin
    if (!i_fsm_rstn || i_clear) begin
      r_nidx       <= 3'd0;
      r_nre        <= 16'd0;
      r_need_noise <= 1'b1;
    end else if (i_load) begin
      r_nidx       <= 3'd0;
      r_need_noise <= 1'b0;
    end else if (i_advance) begin
      if (w_nre_next >= {1'b0, i_rate_eff}) begin
        r_nre  <= 16'd0;
        r_nidx <= r_nidx + 3'd1;
        if (r_nidx == 3'd7) begin
          r_need_noise <= 1'b1;
        end
      end else begin
        r_nre <= w_nre_next[15:0];
      end
    end
  end

endmodule

// File: rtl/upd_slow_phy_to_llr.sv
// Unpacks 128-bit IQ/noise FIFO words into per-strobe RE pairs for the
// LLR engine. One IQ word (4 REs) yields up to two pairs, 4 cycles per word.
`timescale 1ns/1ps
module upd_slow_phy_to_llr
  import upd_llr_pkg::*;
(
  input  logic              i_core_clk,
  input  logic              i_rx_rstn,
  input  logic              i_rx_fsm_rstn,
  input  logic [15:0]       i_user_iq_noise_rate,
  input  logic [15:0]       i_cur_user_re_amounts,
  input  logic [WORD_W-1:0] IQ_Data_SUM,
  input  logic [WORD_W-1:0] Noise_Data_SUM,
  input  logic              IQ_FIFO_Empty,
  input  logic              Noise_FIFO_Empty,
  output logic              IQ_FIFO_Read_Enable,
  output logic              Noise_FIFO_Read_Enable,
  output logic              o_data_strobe,
  output logic [DATA_W-1:0] o_re0_data_i,
  output logic [DATA_W-1:0] o_re0_data_q,
  output logic [DATA_W-1:0] o_re1_data_i,
  output logic [DATA_W-1:0] o_re1_data_q,
  output logic [DATA_W-1:0] o_noise_data
);

  state_e            r_state;
  logic [15:0]       r_rate_eff;
  logic [16:0]       r_amount_eff;
  logic [16:0]       r_re_count;
  logic [WORD_W-1:0] r_iq_word;

  logic              w_fsm_rstn;
  logic              w_need_noise;
  logic              w_go;
  logic              w_fetch_go;
  logic              w_out;
  logic              w_hi;
  logic [15:0]       w_rate_even;
  logic [15:0]       w_rate_eff;
  logic [16:0]       w_amount_inc;
  logic [16:0]       w_amount_eff;
  logic [16:0]       w_re_next;
  logic [DATA_W-1:0] w_noise;

  // Either reset aborts the current user, so the FSM sees both.
  assign w_fsm_rstn   = i_rx_rstn & i_rx_fsm_rstn;

  // Even rate, at least 2, keeps noise changes on pair boundaries.
  assign w_rate_even  = i_user_iq_noise_rate & 16'hFFFE;
  assign w_rate_eff   = (w_rate_even < 16'd2) ? 16'd2 : w_rate_even;
  // Odd RE amounts round up to a whole pair; 17 bits so 16'hFFFF survives.
  assign w_amount_inc = {1'b0, i_cur_user_re_amounts} + 17'd1;
  assign w_amount_eff = w_amount_inc & 17'h1FFFE;
  assign w_re_next    = r_re_count + 17'd2;

  assign w_go         = !IQ_FIFO_Empty && (!w_need_noise || !Noise_FIFO_Empty);
  assign w_fetch_go   = (r_state == ST_FETCH) && w_go && w_fsm_rstn;
  assign w_out        = ((r_state == ST_OUT0) || (r_state == ST_OUT1)) && w_fsm_rstn;
  assign w_hi         = (r_state == ST_OUT1);

  // Pops are combinational so the FIFO sees them in the same cycle as go.
  assign IQ_FIFO_Read_Enable    = w_fetch_go;
  assign Noise_FIFO_Read_Enable = w_fetch_go && w_need_noise;

  upd_llr_noise_sel u_noise_sel (
    .i_core_clk   (i_core_clk),
    .i_rx_rstn    (i_rx_rstn),
    .i_fsm_rstn   (w_fsm_rstn),
    .i_clear      (r_state == ST_IDLE),
    .i_load       ((r_state == ST_CAPT) && w_need_noise),
    .i_noise_word (Noise_Data_SUM),
    .i_advance    (w_out),
    .i_rate_eff   (r_rate_eff),
    .o_noise      (w_noise),
    .o_need_noise (w_need_noise)
  );

  // User sequencing: latch per-user settings, fetch, capture, emit one or two pairs.
  always_ff @(posedge i_core_clk) begin
    if (!w_fsm_rstn) begin
      r_state      <= ST_IDLE;
      r_rate_eff   <= 16'd2;
      r_amount_eff <= 17'd0;
      r_re_count   <= 17'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rate_eff   <= w_rate_eff;
          r_amount_eff <= w_amount_eff;
          r_re_count   <= 17'd0;
          r_state      <= (w_amount_eff != 17'd0) ? ST_FETCH : ST_IDLE;
        end
        ST_FETCH: begin
          r_state <= w_go ? ST_CAPT : ST_FETCH;
        end
        ST_CAPT: begin
          r_state <= ST_OUT0;
        end
        ST_OUT0: begin
          r_re_count <= w_re_next;
          r_state    <= (w_re_next >= r_amount_eff) ? ST_IDLE : ST_OUT1;
        end
        ST_OUT1: begin
          r_re_count <= w_re_next;
          r_state    <= (w_re_next >= r_amount_eff) ? ST_IDLE : ST_FETCH;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // IQ holding register and registered pair outputs; data holds between strobes.
  always_ff @(posedge i_core_clk) begin
    if (!i_rx_rstn) begin
      r_iq_word     <= '0;
      o_data_strobe <= 1'b0;
      o_re0_data_i  <= '0;
      o_re0_data_q  <= '0;
      o_re1_data_i  <= '0;
      o_re1_data_q  <= '0;
      o_noise_data  <= '0;
    end else begin
      o_data_strobe <= w_out;
      if (r_state == ST_CAPT) begin
        r_iq_word <= IQ_Data_SUM;
      end
      if (w_out) begin
        o_re0_data_i <= lane_get(r_iq_word, {w_hi, 2'b00});
        o_re0_data_q <= lane_get(r_iq_word, {w_hi, 2'b01});
        o_re1_data_i <= lane_get(r_iq_word, {w_hi, 2'b10});
        o_re1_data_q <= lane_get(r_iq_word, {w_hi, 2'b11});
        o_noise_data <= w_noise;
      end
    end
  end

endmodule

// File: tb/tb_upd_slow_phy_to_llr.sv
// Self-checking bench: FIFO models feed random words, a reference model
// derives every expected RE pair from the unpacking rules, and a monitor
// compares each strobe against the scoreboard queue.
`timescale 1ns/1ps
module tb_upd_slow_phy_to_llr;

  localparam logic [127:0] PATTERN = {16'h0077, 16'h0066, 16'h0055, 16'h0044,
                                      16'h0033, 16'h0022, 16'h0011, 16'h000C};

  logic         clk;
  logic         i_rx_rstn;
  logic         i_rx_fsm_rstn;
  logic [15:0]  i_user_iq_noise_rate;
  logic [15:0]  i_cur_user_re_amounts;
  logic [127:0] IQ_Data_SUM;
  logic [127:0] Noise_Data_SUM;
  logic         IQ_FIFO_Empty;
  logic         Noise_FIFO_Empty;
  logic         IQ_FIFO_Read_Enable;
  logic         Noise_FIFO_Read_Enable;
  logic         o_data_strobe;
  logic [15:0]  o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q, o_noise_data;

  upd_slow_phy_to_llr dut (
    .i_core_clk             (clk),
    .i_rx_rstn              (i_rx_rstn),
    .i_rx_fsm_rstn          (i_rx_fsm_rstn),
    .i_user_iq_noise_rate   (i_user_iq_noise_rate),
    .i_cur_user_re_amounts  (i_cur_user_re_amounts),
    .IQ_Data_SUM            (IQ_Data_SUM),
    .Noise_Data_SUM         (Noise_Data_SUM),
    .IQ_FIFO_Empty          (IQ_FIFO_Empty),
    .Noise_FIFO_Empty       (Noise_FIFO_Empty),
    .IQ_FIFO_Read_Enable    (IQ_FIFO_Read_Enable),
    .Noise_FIFO_Read_Enable (Noise_FIFO_Read_Enable),
    .o_data_strobe          (o_data_strobe),
    .o_re0_data_i           (o_re0_data_i),
    .o_re0_data_q           (o_re0_data_q),
    .o_re1_data_i           (o_re1_data_i),
    .o_re1_data_q           (o_re1_data_q),
    .o_noise_data           (o_noise_data)
  );

  logic [127:0] iq_fifo[$];
  logic [127:0] nz_fifo[$];
  logic [79:0]  exp_q[$];
  int           rd_cyc[$];
  int           st_cyc[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           cyc        = 0;
  int           iq_reads   = 0;
  int           nz_reads   = 0;
  int           strobes    = 0;
  bit           ignore_strobes = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // FIFO models: empty flags set at negedge, pops answered with data one cycle ahead of capture.
  initial begin
    bit in_gap;
    IQ_FIFO_Empty    = 1'b1;
    Noise_FIFO_Empty = 1'b1;
    IQ_Data_SUM      = '0;
    Noise_Data_SUM   = '0;
    forever begin
      @(negedge clk);
      in_gap           = ($time >= 2130) && ($time < 2910);
      IQ_FIFO_Empty    = (iq_fifo.size() == 0) || in_gap;
      Noise_FIFO_Empty = (nz_fifo.size() == 0);
      #1;
      if (in_gap) check("no_read_in_gap", IQ_FIFO_Read_Enable, 1'b0);
      if (IQ_FIFO_Read_Enable) begin
        if (iq_fifo.size() == 0) begin
          check("iq_underflow", 1'b1, 1'b0);
        end else begin
          IQ_Data_SUM = iq_fifo.pop_front();
          iq_reads++;
          rd_cyc.push_back(cyc);
        end
      end
      if (Noise_FIFO_Read_Enable) begin
        if (nz_fifo.size() == 0) begin
          check("noise_underflow", 1'b1, 1'b0);
        end else begin
          Noise_Data_SUM = nz_fifo.pop_front();
          nz_reads++;
        end
      end
    end
  end

  // Monitor: every strobe pops one expected pair from the scoreboard.
  initial begin
    logic [79:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (($time >= 2170) && ($time < 2910)) check("no_strobe_in_gap", o_data_strobe, 1'b0);
      if (o_data_strobe && !ignore_strobes) begin
        strobes++;
        st_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("pair", {o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q, o_noise_data}, e);
        end
      end
    end
  end

  // Reference model: pair p uses IQ word p/2 (half p%2) and global noise lane p/(rate_eff/2).
  task automatic run_user(input int amount, input int rate, input bit fixed_data);
    int rate_eff, pairs, words, per_lane, nwords, iq0, nz0, st0, g, h;
    logic [127:0] iw[$];
    logic [127:0] nw[$];
    logic [127:0] w, n;
    bit started;
    rate_eff = rate - (rate % 2);
    if (rate_eff < 2) rate_eff = 2;
    pairs    = (amount + 1) / 2;
    words    = (pairs + 1) / 2;
    per_lane = rate_eff / 2;
    nwords   = ((pairs - 1) / per_lane) / 8 + 1;
    for (int k = 0; k < words; k++) begin
      w = (fixed_data && k == 0) ? PATTERN : rand_word();
      iw.push_back(w);
    end
    for (int k = 0; k < nwords; k++) begin
      n = fixed_data ? PATTERN : rand_word();
      nw.push_back(n);
    end
    for (int p = 0; p < pairs; p++) begin
      w = iw[p / 2];
      h = (p % 2) * 4;
      g = p / per_lane;
      n = nw[g / 8];
      exp_q.push_back({w[16*h +: 16], w[16*(h+1) +: 16], w[16*(h+2) +: 16],
                       w[16*(h+3) +: 16], n[16*(g%8) +: 16]});
    end
    iq0 = iq_reads;
    nz0 = nz_reads;
    st0 = strobes;
    i_user_iq_noise_rate  = rate[15:0];
    i_cur_user_re_amounts = amount[15:0];
    foreach (iw[k]) iq_fifo.push_back(iw[k]);
    foreach (nw[k]) nz_fifo.push_back(nw[k]);
    started = 1'b0;
    for (int c = 0; c < 200 && !started; c++) begin
      @(negedge clk);
      #2;
      if (iq_reads > iq0) started = 1'b1;
    end
    i_cur_user_re_amounts = 16'd0;
    check("user_started", started, 1'b1);
    for (int c = 0; c < words * 4 + 300 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("user_done_pairs_left", exp_q.size(), 0);
    exp_q.delete();
    check("strobe_count", strobes - st0, pairs);
    check("iq_reads", iq_reads - iq0, words);
    check("noise_reads", nz_reads - nz0, nwords);
    iq_fifo.delete();
    nz_fifo.delete();
  endtask

  initial begin
    bit found;
    int iq0;
    i_rx_rstn             = 1'b0;
    i_rx_fsm_rstn         = 1'b0;
    i_user_iq_noise_rate  = 16'd0;
    i_cur_user_re_amounts = 16'd0;
    #92;
    check("reset_outputs", {IQ_FIFO_Read_Enable, Noise_FIFO_Read_Enable, o_data_strobe,
                            o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q, o_noise_data}, '0);
    #8;
    i_rx_rstn     = 1'b1;
    i_rx_fsm_rstn = 1'b1;

    // Long user spanning the IQ empty gap; cadence checked on its first words.
    rd_cyc.delete();
    st_cyc.delete();
    run_user(1800, 6, 1'b1);
    if (rd_cyc.size() >= 2 && st_cyc.size() >= 3) begin
      check("first_strobe_latency", st_cyc[0] - rd_cyc[0], 3);
      check("pair_spacing", st_cyc[1] - st_cyc[0], 1);
      check("word_spacing", st_cyc[2] - st_cyc[1], 3);
      check("read_cadence", rd_cyc[1] - rd_cyc[0], 4);
    end else begin
      check("cadence_samples", 1'b0, 1'b1);
    end

    run_user(6, 6, 1'b0);
    run_user(1, 3, 1'b0);
    run_user(7, 0, 1'b0);
    run_user(50, 65535, 1'b0);
    for (int u = 0; u < 6; u++) run_user($urandom_range(120, 1), $urandom_range(20, 0), 1'b0);

    // FSM reset while a pop is in progress: pop must drop in the same cycle.
    ignore_strobes = 1'b1;
    iq0 = iq_reads;
    i_user_iq_noise_rate  = 16'd4;
    i_cur_user_re_amounts = 16'd40;
    for (int k = 0; k < 10; k++) iq_fifo.push_back(rand_word());
    for (int k = 0; k < 2; k++) nz_fifo.push_back(rand_word());
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #3;
      if (IQ_FIFO_Read_Enable && (iq_reads - iq0) >= 3) found = 1'b1;
    end
    i_cur_user_re_amounts = 16'd0;
    check("fsm_rst_found_read", found, 1'b1);
    i_rx_fsm_rstn = 1'b0;
    #1;
    check("rd_en_drop_fsm_rst", {IQ_FIFO_Read_Enable, Noise_FIFO_Read_Enable}, 2'b00);
    repeat (3) @(negedge clk);
    #3;
    i_rx_fsm_rstn = 1'b1;
    iq_fifo.delete();
    nz_fifo.delete();
    ignore_strobes = 1'b0;
    repeat (10) @(negedge clk);
    run_user(20, 4, 1'b0);

    // Datapath reset during output: everything reads 0 after the next edge.
    ignore_strobes = 1'b1;
    iq0 = iq_reads;
    i_user_iq_noise_rate  = 16'd2;
    i_cur_user_re_amounts = 16'd40;
    for (int k = 0; k < 10; k++) iq_fifo.push_back(rand_word());
    for (int k = 0; k < 3; k++) nz_fifo.push_back(rand_word());
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #3;
      if (o_data_strobe && (iq_reads - iq0) >= 2) found = 1'b1;
    end
    i_cur_user_re_amounts = 16'd0;
    check("rx_rst_found_strobe", found, 1'b1);
    i_rx_rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rx_rst_outputs", {IQ_FIFO_Read_Enable, Noise_FIFO_Read_Enable, o_data_strobe,
                             o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q, o_noise_data}, '0);
    repeat (2) @(negedge clk);
    #3;
    i_rx_rstn = 1'b1;
    iq_fifo.delete();
    nz_fifo.delete();
    ignore_strobes = 1'b0;
    repeat (10) @(negedge clk);
    run_user(30, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
